// File: rtl/timer_bank_pkg.sv
// +----------------------------------------------------------------------+
// | timer_bank_pkg : register map and CTRL bit positions for timer_bank  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package timer_bank_pkg;

  localparam logic [3:0] TB_INDEX    = 4'h0;
  localparam logic [3:0] TB_PERIOD0  = 4'h1;
  localparam logic [3:0] TB_PERIOD1  = 4'h2;
  localparam logic [3:0] TB_PERIOD2  = 4'h3;
  localparam logic [3:0] TB_PERIOD3  = 4'h4;
  localparam logic [3:0] TB_LOAD     = 4'h5;
  localparam logic [3:0] TB_CTRL     = 4'h6;
  localparam logic [3:0] TB_STATUS   = 4'h7;
  localparam logic [3:0] TB_STATUS_H = 4'h8;
  localparam logic [3:0] TB_MASK_L   = 4'h9;
  localparam logic [3:0] TB_MASK_H   = 4'hA;
  localparam logic [3:0] TB_VALUE0   = 4'hC;
  localparam logic [3:0] TB_VALUE1   = 4'hD;
  localparam logic [3:0] TB_VALUE2   = 4'hE;
  localparam logic [3:0] TB_VALUE3   = 4'hF;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_OS_BIT = 1;

endpackage

`default_nettype wire

// File: rtl/timer_bank_if.sv
// +----------------------------------------------------------------------+
// | timer_bank_if : CPU byte register bus of the timer bank              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface timer_bank_if;
  logic       cs;
  logic [3:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;

  modport master (output cs, addr, wr_en, wr_data, input rd_data);
  modport slave  (input cs, addr, wr_en, wr_data, output rd_data);
endinterface

`default_nettype wire

// File: rtl/timer_bank_channel.sv
// +----------------------------------------------------------------------+
// | timer_bank_channel : one up-counter with shadowed period, one-shot   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module timer_bank_channel
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_en,
  input  logic             period_wr,
  input  logic [1:0]       period_byte,
  input  logic [7:0]       wr_data,
  input  logic             load,
  input  logic             ctrl_wr,
  input  logic             status_clr,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] value,
  output logic             enable,
  output logic             oneshot,
  output logic             status
);

  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] committed_q, committed_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             enable_q, enable_d;
  logic             oneshot_q, oneshot_d;
  logic             status_q, status_d;
  logic [31:0]      period_merge;
  logic             count_ok;
  logic             expire;

  always_comb begin
    period_merge = 32'(period_q);
    period_merge[{period_byte, 3'b000} +: 8] = wr_data;
    period_d    = period_wr ? period_merge[WIDTH-1:0] : period_q;
    committed_d = committed_q;
    value_d     = value_q;
    enable_d    = enable_q;
    oneshot_d   = oneshot_q;
    status_d    = status_q;

    count_ok = tick_en & enable_q & (committed_q != '0);
    expire   = count_ok & (value_q == committed_q - WIDTH'(1));

    if (count_ok) begin
      if (expire) begin
        value_d = '0;
        if (oneshot_q) enable_d = 1'b0;
      end else begin
        value_d = value_q + WIDTH'(1);
      end
    end
    if (load) begin
      value_d     = '0;
      committed_d = period_q;
    end
    if (ctrl_wr) begin
      enable_d  = wr_data[CTRL_EN_BIT];
      oneshot_d = wr_data[CTRL_OS_BIT];
    end
    // expiry is applied after the clear so a colliding W1C loses
    if (status_clr) status_d = 1'b0;
    if (expire)     status_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q    <= '0;
      committed_q <= '0;
      value_q     <= '0;
      enable_q    <= 1'b0;
      oneshot_q   <= 1'b0;
      status_q    <= 1'b0;
    end else begin
      period_q    <= period_d;
      committed_q <= committed_d;
      value_q     <= value_d;
      enable_q    <= enable_d;
      oneshot_q   <= oneshot_d;
      status_q    <= status_d;
    end
  end

  assign period  = period_q;
  assign value   = value_q;
  assign enable  = enable_q;
  assign oneshot = oneshot_q;
  assign status  = status_q;

endmodule

`default_nettype wire

// File: rtl/timer_bank.sv
// +----------------------------------------------------------------------+
// | timer_bank : CHANNELS programmable timers, byte register bus, IRQ    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 20,
  parameter int IDX_W    = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick_en,
  timer_bank_if.slave         bus,
  output logic                irq,
  output logic [CHANNELS-1:0] irq_status
);

  logic [7:0]          index_q, index_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [WIDTH-1:0]    snap_q, snap_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                irq_q, irq_d;

  logic [WIDTH-1:0]    ch_period [CHANNELS];
  logic [WIDTH-1:0]    ch_value  [CHANNELS];
  logic [CHANNELS-1:0] ch_en, ch_os, ch_status, ch_sel, status_clr;

  logic             wr, rd, in_range, period_wr, load, ctrl_wr;
  logic [3:0]       addr_m1;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sel_period, sel_value;
  logic             sel_en, sel_os;
  logic [31:0]      period_ext, snap_ext;
  logic [15:0]      status_ext, mask_ext;
  logic [7:0]       rd_mux;

  always_comb begin
    wr        = bus.cs & bus.wr_en;
    rd        = bus.cs & ~bus.wr_en;
    in_range  = index_q < 8'(CHANNELS);
    idx       = index_q[IDX_W-1:0];
    addr_m1   = bus.addr - 4'h1;
    period_wr = wr & (bus.addr >= TB_PERIOD0) & (bus.addr <= TB_PERIOD3);
    load      = wr & (bus.addr == TB_LOAD);
    ctrl_wr   = wr & (bus.addr == TB_CTRL);

    // out-of-range index selects nothing and reads back as zero
    sel_period = in_range ? ch_period[idx] : '0;
    sel_value  = in_range ? ch_value[idx]  : '0;
    sel_en     = in_range & ch_en[idx];
    sel_os     = in_range & ch_os[idx];

    index_d = (wr && bus.addr == TB_INDEX) ? bus.wr_data : index_q;
    mask_d  = mask_q;
    for (int i = 0; i < CHANNELS; i++) begin
      status_clr[i] = wr & (bus.addr == ((i < 8) ? TB_STATUS : TB_STATUS_H)) & bus.wr_data[i % 8];
      if (wr && bus.addr == ((i < 8) ? TB_MASK_L : TB_MASK_H)) mask_d[i] = bus.wr_data[i % 8];
    end

    period_ext = 32'(sel_period);
    snap_ext   = 32'(snap_q);
    status_ext = 16'(ch_status);
    mask_ext   = 16'(mask_q);
    rd_mux     = 8'h00;
    case (bus.addr)
      TB_INDEX:    rd_mux = index_q;
      TB_PERIOD0, TB_PERIOD1, TB_PERIOD2, TB_PERIOD3:
                   rd_mux = period_ext[{addr_m1[1:0], 3'b000} +: 8];
      TB_CTRL:     rd_mux = {6'b0, sel_os, sel_en};
      TB_STATUS:   rd_mux = status_ext[7:0];
      TB_STATUS_H: rd_mux = status_ext[15:8];
      TB_MASK_L:   rd_mux = mask_ext[7:0];
      TB_MASK_H:   rd_mux = mask_ext[15:8];
      TB_VALUE0:   rd_mux = sel_value[7:0];
      TB_VALUE1, TB_VALUE2, TB_VALUE3:
                   rd_mux = snap_ext[{bus.addr[1:0], 3'b000} +: 8];
      default:     rd_mux = 8'h00;
    endcase

    rd_data_d = bus.cs ? rd_mux : rd_data_q;
    snap_d    = (rd && bus.addr == TB_VALUE0) ? sel_value : snap_q;
    irq_d     = |(ch_status & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q   <= '0;
      mask_q    <= '0;
      snap_q    <= '0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      index_q   <= index_d;
      mask_q    <= mask_d;
      snap_q    <= snap_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    assign ch_sel[i] = in_range && (index_q == 8'(i));

    timer_bank_channel #(.WIDTH(WIDTH)) u_channel (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick_en    (tick_en),
      .period_wr  (period_wr & ch_sel[i]),
      .period_byte(addr_m1[1:0]),
      .wr_data    (bus.wr_data),
      .load       (load & ch_sel[i]),
      .ctrl_wr    (ctrl_wr & ch_sel[i]),
      .status_clr (status_clr[i]),
      .period     (ch_period[i]),
      .value      (ch_value[i]),
      .enable     (ch_en[i]),
      .oneshot    (ch_os[i]),
      .status     (ch_status[i])
    );
  end

  assign bus.rd_data = rd_data_q;
  assign irq         = irq_q;
  assign irq_status  = ch_status;

endmodule

`default_nettype wire

// File: tb/tb_timer_bank.sv
// +----------------------------------------------------------------------+
// | tb_timer_bank : self-checking bench for timer_bank (8 x 20-bit)      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_timer_bank;
  import timer_bank_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_en = 1'b0;
  logic       irq;
  logic [7:0] irq_status;

  timer_bank_if bus ();

  timer_bank #(.CHANNELS(8), .WIDTH(20), .IDX_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick_en   (tick_en),
    .bus       (bus),
    .irq       (irq),
    .irq_status(irq_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic       wr;
    logic [7:0] data;
    logic [7:0] exp;
    string      name;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  string      name_q[$];
  vec_t       vecs[$];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.wr_en = 1'b1; bus.addr = a; bus.wr_data = d;
    step(1);
    bus.cs = 1'b0; bus.wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [7:0] e, input string nm);
    logic [7:0] want;
    bus.cs = 1'b1; bus.wr_en = 1'b0; bus.addr = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    step(1);
    bus.cs = 1'b0;
    want = exp_q.pop_front();
    check(name_q.pop_front(), {24'h0, bus.rd_data}, {24'h0, want});
  endtask

  function automatic void add(input logic [3:0] a, input logic w, input logic [7:0] d,
                              input logic [7:0] e, input string nm);
    vecs.push_back('{a, w, d, e, nm});
  endfunction

  task automatic test_regs();
    add(TB_INDEX,   0, 8'h00, 8'h00, "rst_index");
    add(TB_STATUS,  0, 8'h00, 8'h00, "rst_status");
    add(TB_MASK_L,  0, 8'h00, 8'h00, "rst_mask");
    add(TB_INDEX,   1, 8'h01, 8'h00, "");
    add(TB_INDEX,   0, 8'h00, 8'h01, "index_rb");
    add(TB_PERIOD0, 1, 8'h34, 8'h00, "");
    add(TB_PERIOD1, 1, 8'h12, 8'h00, "");
    add(TB_PERIOD2, 1, 8'hAB, 8'h00, "");
    add(TB_PERIOD3, 1, 8'hCD, 8'h00, "");
    add(TB_PERIOD0, 0, 8'h00, 8'h34, "period_b0");
    add(TB_PERIOD1, 0, 8'h00, 8'h12, "period_b1");
    add(TB_PERIOD2, 0, 8'h00, 8'h0B, "period_b2_trunc");
    add(TB_PERIOD3, 0, 8'h00, 8'h00, "period_b3_absent");
    add(TB_CTRL,    1, 8'hFF, 8'h00, "");
    add(TB_CTRL,    0, 8'h00, 8'h03, "ctrl_bits");
    add(TB_CTRL,    1, 8'h00, 8'h00, "");
    add(TB_CTRL,    0, 8'h00, 8'h00, "ctrl_clear");
    add(TB_MASK_L,  1, 8'hA5, 8'h00, "");
    add(TB_MASK_L,  0, 8'h00, 8'hA5, "mask_l");
    add(TB_MASK_H,  1, 8'hFF, 8'h00, "");
    add(TB_MASK_H,  0, 8'h00, 8'h00, "mask_h_absent");
    add(TB_MASK_L,  1, 8'h00, 8'h00, "");
    add(TB_INDEX,   1, 8'h09, 8'h00, "");
    add(TB_INDEX,   0, 8'h00, 8'h09, "index_oor_rb");
    add(TB_PERIOD0, 0, 8'h00, 8'h00, "period_oor_rd");
    add(TB_PERIOD0, 1, 8'h77, 8'h00, "");
    add(TB_INDEX,   1, 8'h01, 8'h00, "");
    add(TB_PERIOD0, 0, 8'h00, 8'h34, "period_oor_nowr");
    add(TB_INDEX,   1, 8'h00, 8'h00, "");
    add(TB_PERIOD0, 0, 8'h00, 8'h00, "period_ch0");
    add(TB_VALUE0,  0, 8'h00, 8'h00, "value_rst");
    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else            bus_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
  endtask

  task automatic test_periodic();
    tick_en = 1'b1;
    bus_write(TB_INDEX, 8'd2);
    bus_write(TB_PERIOD0, 8'd5);
    bus_write(TB_LOAD, 8'h00);
    bus_write(TB_CTRL, 8'h01);
    step(4);
    check("per_before", {24'h0, irq_status}, 32'h00);
    step(1);
    check("per_fire", {24'h0, irq_status}, 32'h04);
    check("per_unmasked_irq", {31'h0, irq}, 32'h0);
    bus_write(TB_MASK_L, 8'h04);
    check("per_irq_lat", {31'h0, irq}, 32'h0);
    step(1);
    check("per_irq_rise", {31'h0, irq}, 32'h1);
    bus_write(TB_STATUS, 8'h04);
    check("per_w1c", {24'h0, irq_status}, 32'h00);
    check("per_irq_hold", {31'h0, irq}, 32'h1);
    step(1);
    check("per_irq_fall", {31'h0, irq}, 32'h0);
    step(1);
    check("per_refire", {24'h0, irq_status}, 32'h04);
    bus_read(TB_CTRL, 8'h01, "per_ctrl_rd");
    bus_write(TB_CTRL, 8'h00);
    bus_write(TB_STATUS, 8'hFF);
    bus_write(TB_MASK_L, 8'h00);
  endtask

  task automatic test_oneshot();
    bus_write(TB_INDEX, 8'd0);
    bus_write(TB_PERIOD0, 8'd3);
    bus_write(TB_LOAD, 8'h00);
    bus_write(TB_CTRL, 8'h03);
    step(2);
    check("os_before", {24'h0, irq_status}, 32'h00);
    step(1);
    check("os_fire", {24'h0, irq_status}, 32'h01);
    bus_read(TB_CTRL, 8'h02, "os_ctrl");
    bus_write(TB_STATUS, 8'h01);
    step(6);
    check("os_no_refire", {24'h0, irq_status}, 32'h00);
    bus_read(TB_VALUE0, 8'h00, "os_value_hold");
  endtask

  task automatic test_collision();
    bus_write(TB_MASK_L, 8'h01);
    bus_write(TB_CTRL, 8'h01);
    step(2);
    bus_write(TB_STATUS, 8'h01);
    check("w1c_set_wins", {24'h0, irq_status}, 32'h01);
    bus_write(TB_CTRL, 8'h00);
    check("w1c_irq_up", {31'h0, irq}, 32'h1);
    bus_write(TB_STATUS, 8'h01);
    check("w1c_cleared", {24'h0, irq_status}, 32'h00);
    check("w1c_irq_hold", {31'h0, irq}, 32'h1);
    step(1);
    check("w1c_irq_fall", {31'h0, irq}, 32'h0);
    bus_read(TB_VALUE0, 8'h01, "pause_value");
    step(3);
    bus_read(TB_VALUE0, 8'h01, "pause_hold");
    bus_write(TB_CTRL, 8'h01);
    step(1);
    check("resume_count", {24'h0, irq_status}, 32'h00);
    step(1);
    check("resume_fire", {24'h0, irq_status}, 32'h01);
    bus_write(TB_CTRL, 8'h00);
    bus_write(TB_STATUS, 8'hFF);
    bus_write(TB_MASK_L, 8'h00);
  endtask

  task automatic test_tearfree();
    bus_write(TB_INDEX, 8'd3);
    bus_write(TB_PERIOD0, 8'hFF);
    bus_write(TB_PERIOD1, 8'hFF);
    bus_write(TB_PERIOD2, 8'h0F);
    bus_write(TB_LOAD, 8'h00);
    bus_write(TB_CTRL, 8'h01);
    step(255);
    bus_read(TB_VALUE0, 8'hFF, "snap_b0");
    bus_read(TB_VALUE1, 8'h00, "snap_b1");
    bus_read(TB_VALUE2, 8'h00, "snap_b2");
    bus_read(TB_VALUE0, 8'h02, "snap2_b0");
    bus_read(TB_VALUE1, 8'h01, "snap2_b1");
    bus_write(TB_CTRL, 8'h00);
  endtask

  task automatic test_prescale();
    logic clr;
    logic seen;
    tick_en = 1'b0;
    bus_write(TB_INDEX, 8'd4);
    bus_write(TB_PERIOD0, 8'd2);
    bus_write(TB_LOAD, 8'h00);
    bus_write(TB_CTRL, 8'h01);
    for (int c = 0; c < 32; c++) begin
      tick_en = (c % 4 == 0);
      clr = (c % 8 == 5);
      bus.cs = clr; bus.wr_en = clr; bus.addr = TB_STATUS; bus.wr_data = 8'h10;
      step(1);
      check($sformatf("presc_c%0d", c), {24'h0, irq_status}, (c % 8 == 4) ? 32'h10 : 32'h00);
    end
    bus.cs = 1'b0; bus.wr_en = 1'b0;
    bus_write(TB_CTRL, 8'h00);
    bus_write(TB_STATUS, 8'hFF);

    tick_en = 1'b1;
    bus_write(TB_INDEX, 8'd5);
    bus_write(TB_PERIOD0, 8'd0);
    bus_write(TB_LOAD, 8'h00);
    bus_write(TB_MASK_L, 8'h20);
    bus_write(TB_CTRL, 8'h01);
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      step(1);
      seen = seen | irq_status[5] | irq;
    end
    check("period0_never", {31'h0, seen}, 32'h0);
    bus_read(TB_VALUE0, 8'h00, "period0_value");
    bus_write(TB_CTRL, 8'h00);
    bus_write(TB_MASK_L, 8'h00);
  endtask

  task automatic test_reset();
    bus_write(TB_INDEX, 8'd6);
    bus_write(TB_PERIOD0, 8'd2);
    bus_write(TB_LOAD, 8'h00);
    bus_write(TB_MASK_L, 8'h40);
    bus_write(TB_CTRL, 8'h01);
    step(6);
    check("rst_pre_irq", {31'h0, irq}, 32'h1);
    bus_read(TB_INDEX, 8'h06, "rst_pre_rd");
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_irq", {31'h0, irq}, 32'h0);
    check("rst_async_rd", {24'h0, bus.rd_data}, 32'h00);
    check("rst_async_status", {24'h0, irq_status}, 32'h00);
    step(2);
    reset_n = 1'b1;
    step(20);
    check("rst_idle_status", {24'h0, irq_status}, 32'h00);
    check("rst_idle_irq", {31'h0, irq}, 32'h0);
    bus_read(TB_INDEX, 8'h00, "rst_index_cleared");
    bus_write(TB_INDEX, 8'd6);
    bus_read(TB_CTRL, 8'h00, "rst_ctrl_cleared");
    bus_read(TB_PERIOD0, 8'h00, "rst_period_cleared");
    bus_read(TB_MASK_L, 8'h00, "rst_mask_cleared");
  endtask

  initial begin
    bus.cs = 1'b0; bus.wr_en = 1'b0; bus.addr = 4'h0; bus.wr_data = 8'h00;
    step(2);
    reset_n = 1'b1;
    check("rst_rd_data", {24'h0, bus.rd_data}, 32'h00);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_irq_status", {24'h0, irq_status}, 32'h00);
    step(1);
    test_regs();
    test_periodic();
    test_oneshot();
    test_collision();
    test_tearfree();
    test_prescale();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
